// File: rtl/pfu_pkg.sv
// Shared definitions for the prefetch unit: FSM encoding, reset vector, instruction width.
package pfu_pkg;

    localparam int unsigned C_INS_W         = 32;
    localparam logic [31:0] C_PFU_RESET_VEC = 32'h0000_0000;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } pfu_state_e;

endpackage : pfu_pkg

// File: rtl/pfu_fifo.sv
// Fetch buffer: power-of-two circular FIFO with synchronous flush and occupancy count.
module pfu_fifo #(
    parameter int unsigned C_WIDTH = 64,
    parameter int unsigned C_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           resetb_i,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_flush,
    input  logic [C_WIDTH-1:0]             i_data,
    output logic [C_WIDTH-1:0]             o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(C_DEPTH):0]       o_count
);

    localparam int unsigned C_PTR_W = $clog2(C_DEPTH);
    localparam int unsigned C_CNT_W = C_PTR_W + 1;

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Overflow/underflow protection: ignore push when full, pop when empty.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    assign o_full  = (r_count == C_CNT_W'(C_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and count; flush has priority over push and pop.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : pfu_fifo

// File: rtl/pfu.sv
// Prefetch unit: issues one instruction fetch at a time, buffers responses for decode,
// and accepts PC redirects while no request is outstanding.
module pfu
    import pfu_pkg::*;
#(
    parameter int unsigned        C_XLEN       = 32,
    parameter int unsigned        C_FIFO_DEPTH = 4,
    parameter logic [C_XLEN-1:0]  C_RESET_VEC  = C_XLEN'(C_PFU_RESET_VEC)
) (
    input  logic                clk_i,
    input  logic                resetb_i,
    input  logic                clk_en_i,
    output logic                pc_ready_o,
    input  logic                pc_wr_i,
    input  logic [C_XLEN-1:0]   pc_i,
    output logic                ireqvalid_o,
    input  logic                ireqready_i,
    output logic [C_XLEN-1:0]   ireqaddr_o,
    input  logic                irspvalid_i,
    input  logic [C_INS_W-1:0]  irspdata_i,
    output logic                ids_valid_o,
    input  logic                ids_ready_i,
    output logic [C_INS_W-1:0]  ids_ins_o,
    output logic [C_XLEN-1:0]   ids_pc_o
);

    localparam int unsigned C_ENT_W = C_XLEN + C_INS_W;
    localparam int unsigned C_CNT_W = $clog2(C_FIFO_DEPTH) + 1;

    pfu_state_e          r_state;
    pfu_state_e          w_state_nxt;
    logic [C_XLEN-1:0]   r_fetch_pc;
    logic [C_XLEN-1:0]   r_rsp_pc;

    logic                w_redirect;
    logic                w_req_fire;
    logic                w_rsp_fire;
    logic                w_space;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic [C_CNT_W-1:0]  w_count;
    logic [C_ENT_W-1:0]  w_head;

    // Handshake qualifiers; every state change is gated by the clock enable.
    assign w_space    = (w_count < C_CNT_W'(C_FIFO_DEPTH));
    assign w_redirect = pc_wr_i & (r_state == ST_REQ);
    assign w_req_fire = ireqvalid_o & ireqready_i;
    assign w_rsp_fire = (r_state == ST_WAIT) & irspvalid_i;
    assign w_push     = clk_en_i & w_rsp_fire & ~w_full;
    assign w_pop      = clk_en_i & ids_ready_i & ~w_empty;
    assign w_flush    = clk_en_i & w_redirect;

    // Fetch FSM state register.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= ST_REQ;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch FSM next state and request/redirect handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        pc_ready_o  = 1'b0;
        ireqvalid_o = 1'b0;
        case (r_state)
            ST_REQ: begin
                pc_ready_o  = 1'b1;
                ireqvalid_o = w_space & ~pc_wr_i;
                if (ireqvalid_o && ireqready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (irspvalid_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    // Fetch PC (redirect or sequential advance) and PC of the outstanding request.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fetch_pc <= C_RESET_VEC;
            r_rsp_pc   <= C_RESET_VEC;
        end else if (clk_en_i) begin
            if (w_redirect) begin
                r_fetch_pc <= pc_i & ~C_XLEN'(3);
            end else if (w_rsp_fire) begin
                r_fetch_pc <= r_fetch_pc + C_XLEN'(4);
            end
            if (w_req_fire) begin
                r_rsp_pc <= r_fetch_pc;
            end
        end
    end

    assign ireqaddr_o  = r_fetch_pc;
    assign ids_valid_o = ~w_empty;
    assign ids_pc_o    = w_head[C_ENT_W-1:C_INS_W];
    assign ids_ins_o   = w_head[C_INS_W-1:0];

    pfu_fifo #(
        .C_WIDTH (C_ENT_W),
        .C_DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetb_i (resetb_i),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (w_flush),
        .i_data   ({r_rsp_pc, irspdata_i}),
        .o_data   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

endmodule : pfu

// File: doc/pfu.md
PFU -- requirements
Module: pfu

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- C_XLEN, 32, datapath and address width
- C_FIFO_DEPTH, 4, fetch buffer entries (power of two, >=2)
- C_RESET_VEC, 32'h0000_0000, first fetch address after reset
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk_i, in, 1, clock
- resetb_i, in, 1, asynchronous active-low reset
- clk_en_i, in, 1, global clock enable; when low, all state holds
- pc_ready_o, out, 1, redirect can be accepted this cycle
- pc_wr_i, in, 1, redirect request from vectoring block
- pc_i, in, C_XLEN, redirect target
- ireqvalid_o, out, 1, instruction fetch request
- ireqready_i, in, 1, memory accepts request
- ireqaddr_o, out, C_XLEN, fetch address
- irspvalid_i, in, 1, fetch response valid
- irspdata_i, in, 32, fetched instruction
- ids_valid_o, out, 1, instruction available to decode
- ids_ready_i, in, 1, decode consumes instruction
- ids_ins_o, out, 32, instruction word
- ids_pc_o, out, C_XLEN, address of ids_ins_o

Function
REQ-003 Fetch FSM SHALL have states REQ (may issue) and WAIT (one request outstanding); at most one request outstanding.
REQ-004 In REQ, ireqvalid_o SHALL equal (fifo count < C_FIFO_DEPTH) AND NOT (pc_wr_i AND pc_ready_o); ireqaddr_o = fetch PC.
REQ-005 ireqvalid_o AND ireqready_i SHALL move REQ->WAIT and latch fetch PC as response PC.
REQ-006 In WAIT, irspvalid_i SHALL push {response PC, irspdata_i} into FIFO, increment fetch PC by 4 (modulo 2^C_XLEN), and return to REQ.
REQ-007 pc_ready_o SHALL be 1 in REQ and 0 in WAIT.
REQ-008 Redirect (pc_wr_i AND pc_ready_o) SHALL: load fetch PC with {pc_i[C_XLEN-1:2],2'b00}; flush FIFO next cycle; suppress any request that cycle.
REQ-009 A redirect with pc_ready_o low SHALL be ignored; the upstream block holds it.
REQ-010 ids_valid_o SHALL be 1 iff the FIFO is non-empty; ids_ins_o/ids_pc_o SHALL show the head entry.
REQ-011 ids_valid_o AND ids_ready_i SHALL pop one entry.
REQ-012 Flush and pop in the same cycle SHALL leave the FIFO empty (flush wins).
REQ-013 Push and pop in the same cycle with the FIFO full SHALL NOT occur, because requests are gated on count < depth. Push and pop together otherwise SHALL keep count unchanged.
REQ-014 Latency SHALL be:
- redirect accept -> ireqvalid_o: 1 cycle
- response -> ids_valid_o: 1 cycle
REQ-015 irspvalid_i in REQ SHALL be ignored.

Reset
REQ-016 Asynchronous reset SHALL set:
- state = REQ
- fetch PC = C_RESET_VEC
- FIFO empty
Consequently, ids_valid_o=0, ireqvalid_o=1, pc_ready_o=1 during and after reset.
REQ-017 Reset mid-request SHALL abandon the outstanding request; any late response is dropped (state REQ).

Structure
REQ-018 The shared package SHALL hold the FSM state encoding, C_RESET_VEC default and the instruction width constant.
REQ-019 The FIFO SHALL be a sub-module pfu_fifo (parameters width and depth; ports push, pop, flush, full, empty, count). Its pointers SHALL wrap modulo C_FIFO_DEPTH.

Verification
REQ-020 Bench SHALL cover:
- Reset, memory always ready, 1-cycle response: addresses 0x0,0x4,0x8,0xC issued; decode receives 4 instructions with matching PCs.
- ids_ready_i held low: FIFO fills to 4, ireqvalid_o drops; after one pop, exactly one new request (0x10).
- Redirect pc_i=0x0000_0103 in REQ: next request address 0x100; FIFO empty next cycle.
- pc_wr_i held while in WAIT: pc_ready_o=0, redirect taken only after response, response pushed then flushed.
- Same-cycle pop and flush with 2 entries: count 0.
- clk_en_i low for 5 cycles mid-WAIT: state, PC and FIFO unchanged.
